// File: rtl/seq_detect_moore_param_if.sv
// Bus for the parametrised Moore sequence detector: serial data, control and status.
// The master drives stimulus and control. The slave is the detector.
interface seq_detect_moore_param_if #(
    parameter int N  = 5,
    parameter int CW = 8
);
    logic          i;
    logic          en;
    logic          overlap;
    logic          load;
    logic [N-1:0]  pattern_in;
    logic          clr_cnt;
    logic          y;
    logic [CW-1:0] match_cnt;
    logic [N-1:0]  pattern;

    modport master (
        output i, en, overlap, load, pattern_in, clr_cnt,
        input  y, match_cnt, pattern
    );

    modport slave (
        input  i, en, overlap, load, pattern_in, clr_cnt,
        output y, match_cnt, pattern
    );
endinterface

// File: rtl/seq_detect_moore_param.sv
// Moore detector for a run-time programmable N-bit serial pattern.
// It supports overlap and non-overlap modes, EN gating and a saturating match counter.
module seq_detect_moore_param #(
    parameter int           N               = 5,
    parameter logic [N-1:0] DEFAULT_PATTERN = 5'b10011,
    parameter int           CW              = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    seq_detect_moore_param_if.slave  bus
);
    localparam int            FW        = $clog2(N + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(N);
    localparam logic [FW-1:0] FILL_ARM  = FW'(N - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    logic [N-1:0]  pat_q,  pat_d;
    logic [N-1:0]  hist_q, hist_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          y_q,    y_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic [N-1:0]  win_s;
    logic          match_s;

    // The incoming bit completes the window. N-1 valid history bits plus I give N bits.
    assign win_s   = {hist_q[N-2:0], bus.i};
    assign match_s = bus.en & ~bus.load & (fill_q >= FILL_ARM) & (win_s == pat_q);

    // Next-state for pattern, history, fill level and the match pulse
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        y_d    = 1'b0;
        if (bus.load) begin
            pat_d  = bus.pattern_in;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.en) begin
            hist_d = win_s;
            y_d    = match_s;
            if (match_s && !bus.overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FW'(1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            y_d = 1'b0;
        end
    end

    // Next-state for the saturating match counter. A clear drops a coincident match.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (match_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pat_q  <= DEFAULT_PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.match_cnt = cnt_q;
    assign bus.pattern   = pat_q;
endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Self-checking bench for seq_detect_moore_param.
// It uses a scoreboard of expected outputs from a behavioural model, plus a small N=2/CW=2 instance for saturation.
module tb_seq_detect_moore_param;
    localparam int           N   = 5;
    localparam int           CW  = 8;
    localparam logic [N-1:0] DEF = 5'b10011;

    typedef struct packed {
        logic          y;
        logic [CW-1:0] cnt;
        logic [N-1:0]  pat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   y_seen;

    exp_t sb_q[$];
    exp_t sb_b_q[$];

    logic [N-1:0]  m_pat;
    logic [N-1:0]  m_hist;
    int            m_fill;
    logic [CW-1:0] m_cnt;

    seq_detect_moore_param_if #(.N(N), .CW(CW)) bus_a ();
    seq_detect_moore_param_if #(.N(2), .CW(2))  bus_b ();

    seq_detect_moore_param #(.N(N), .DEFAULT_PATTERN(DEF), .CW(CW)) u_dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_a.slave)
    );

    seq_detect_moore_param #(.N(2), .DEFAULT_PATTERN(2'b11), .CW(2)) u_dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pat  = DEF;
        m_hist = '0;
        m_fill = 0;
        m_cnt  = '0;
    endtask

    // Drive one cycle on instance A, push the model prediction, then compare after the edge.
    task automatic drive_a(input logic i, input logic en, input logic ovl,
                           input logic load, input logic [N-1:0] pin, input logic clr);
        logic [N-1:0] w;
        logic         m;
        exp_t         e;
        exp_t         got;
        bus_a.i = i; bus_a.en = en; bus_a.overlap = ovl;
        bus_a.load = load; bus_a.pattern_in = pin; bus_a.clr_cnt = clr;
        w = {m_hist[N-2:0], i};
        m = en && !load && (m_fill >= N - 1) && (w == m_pat);
        e.y = 1'b0;
        if (load) begin
            m_pat = pin; m_hist = '0; m_fill = 0;
        end else if (en) begin
            m_hist = w;
            e.y    = m;
            if (m && !ovl) m_fill = 0;
            else if (m_fill < N) m_fill = m_fill + 1;
        end
        if (clr) m_cnt = '0;
        else if (m && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        e.cnt = m_cnt;
        e.pat = m_pat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_eq("y",         32'(bus_a.y),         32'(got.y));
        check_eq("match_cnt", 32'(bus_a.match_cnt), 32'(got.cnt));
        check_eq("pattern",   32'(bus_a.pattern),   32'(got.pat));
        if (bus_a.y === 1'b1) y_seen = y_seen + 1;
    endtask

    task automatic feed(input logic [31:0] bits, input int len, input logic ovl);
        for (int k = len - 1; k >= 0; k--) drive_a(bits[k], 1'b1, ovl, 1'b0, '0, 1'b0);
    endtask

    task automatic drive_b(input logic clr, input logic ey, input logic [1:0] ecnt);
        exp_t e;
        exp_t got;
        bus_b.i = 1'b1; bus_b.en = 1'b1; bus_b.overlap = 1'b1;
        bus_b.load = 1'b0; bus_b.pattern_in = 2'b00; bus_b.clr_cnt = clr;
        e     = '0;
        e.y   = ey;
        e.cnt = CW'(ecnt);
        sb_b_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_b_q.pop_front();
        check_eq("b_y",   32'(bus_b.y),         32'(got.y));
        check_eq("b_cnt", 32'(bus_b.match_cnt), 32'(got.cnt));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        y_seen   = 0;
        rst_n    = 1'b0;
        bus_a.i = 1'b0; bus_a.en = 1'b0; bus_a.overlap = 1'b1;
        bus_a.load = 1'b0; bus_a.pattern_in = '0; bus_a.clr_cnt = 1'b0;
        bus_b.i = 1'b0; bus_b.en = 1'b0; bus_b.overlap = 1'b1;
        bus_b.load = 1'b0; bus_b.pattern_in = '0; bus_b.clr_cnt = 1'b0;
        model_reset();
        #12;
        check_eq("rst_y",   32'(bus_a.y),         32'd0);
        check_eq("rst_cnt", 32'(bus_a.match_cnt), 32'd0);
        check_eq("rst_pat", 32'(bus_a.pattern),   32'(DEF));
        check_eq("rst_b_pat", 32'(bus_b.pattern), 32'd3);
        @(negedge clk);
        rst_n = 1'b1;

        // Overlap mode: pulses after bits 5 and 9
        y_seen = 0;
        feed(32'b100110011, 9, 1'b1);
        check_eq("ovl_pulses", 32'(y_seen),         32'd2);
        check_eq("ovl_cnt",    32'(bus_a.match_cnt), 32'd2);

        // Non-overlap mode: only one pulse
        drive_a(1'b0, 1'b0, 1'b0, 1'b1, DEF, 1'b1);
        y_seen = 0;
        feed(32'b100110011, 9, 1'b0);
        check_eq("novl_pulses", 32'(y_seen),         32'd1);
        check_eq("novl_cnt",    32'(bus_a.match_cnt), 32'd1);

        // EN gating: idle cycles between bits 2 and 3
        drive_a(1'b0, 1'b0, 1'b1, 1'b1, DEF, 1'b0);
        y_seen = 0;
        feed(32'b10, 2, 1'b1);
        for (int k = 0; k < 3; k++) drive_a(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, '0, 1'b0);
        feed(32'b011, 3, 1'b1);
        check_eq("en_pulses", 32'(y_seen), 32'd1);

        // Runtime LOAD discards history and switches the pattern
        feed(32'b1001, 4, 1'b1);
        drive_a(1'b1, 1'b1, 1'b1, 1'b1, 5'b11100, 1'b0);
        y_seen = 0;
        feed(32'b11100, 5, 1'b1);
        check_eq("load_pulses", 32'(y_seen),         32'd1);
        check_eq("load_pat",    32'(bus_a.pattern), 32'h1C);

        // Asynchronous reset mid-sequence
        feed(32'b1001, 4, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("arst_y",   32'(bus_a.y),         32'd0);
        check_eq("arst_cnt", 32'(bus_a.match_cnt), 32'd0);
        check_eq("arst_pat", 32'(bus_a.pattern),   32'(DEF));
        #2;
        rst_n = 1'b1;
        y_seen = 0;
        drive_a(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        check_eq("arst_bare1", 32'(bus_a.y), 32'd0);
        feed(32'b10011, 5, 1'b1);
        check_eq("arst_pulses", 32'(y_seen), 32'd1);

        // CLR_CNT coincident with a match on A
        drive_a(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        drive_a(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        drive_a(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        drive_a(1'b1, 1'b1, 1'b1, 1'b1 & 1'b0, '0, 1'b1);
        check_eq("clr_y", 32'(bus_a.y), 32'd1);
        check_eq("clr_cnt", 32'(bus_a.match_cnt), 32'd0);

        // Saturation on the 2-bit counter, then clear together with a match
        drive_b(1'b0, 1'b0, 2'd0);
        drive_b(1'b0, 1'b1, 2'd1);
        drive_b(1'b0, 1'b1, 2'd2);
        drive_b(1'b0, 1'b1, 2'd3);
        drive_b(1'b0, 1'b1, 2'd3);
        drive_b(1'b1, 1'b1, 2'd0);
        drive_b(1'b0, 1'b1, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/seq_detect_moore_param.md
# seq_detect_moore_param

Parametrised Moore sequence detector. It compares a serial bit stream against an N-bit pattern that is programmable at run time, and supports overlapping and non-overlapping match modes, input gating and a saturating match counter. It sits on the serial input path and replaces the fixed 5-bit, hard-coded detectors. It feeds event/interrupt logic (Y) and status readback (MATCH_CNT).

## Interface
- N, 5: pattern length in bits; legal range 2..32.
- DEFAULT_PATTERN, 5'b10011: pattern loaded at reset; N bits, MSB is the oldest (first-received) bit.
- CW, 8: width of the match counter.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-low; one clock domain.
- I  input  1  serial data bit.
- EN  input  1  data qualifier; I is sampled only when EN=1.
- OVERLAP  input  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- LOAD  input  1  capture PATTERN_IN into the pattern register.
- PATTERN_IN  input  N  new pattern, same bit order as DEFAULT_PATTERN.
- CLR_CNT  input  1  synchronous clear of MATCH_CNT.
- Y  output  1  registered match pulse.
- MATCH_CNT  output  CW  saturating count of matches.
- PATTERN  output  N  current pattern register.

## Operation
- State:
  - pattern register PAT[N-1:0].
  - history shift register HIST[N-1:0]; the newest bit enters the LSB.
  - fill counter FILL, 0..N, saturating at N; it counts valid history bits.
  - Y register.
  - MATCH_CNT.
- Reset (RST=0, asynchronous) sets PAT=DEFAULT_PATTERN, HIST=0, FILL=0, Y=0, MATCH_CNT=0. The outputs hold these values while RST=0.
- Window compare: W = {HIST[N-2:0], I}. match = EN & (FILL >= N-1) & (W == PAT).
- Per rising edge, in priority order:
  1. LOAD=1:
     - PAT <= PATTERN_IN; HIST <= 0; FILL <= 0; Y <= 0.
     - I and EN are ignored this cycle. No match can occur.
  2. EN=1:
     - HIST <= W; Y <= match.
     - On match with OVERLAP=0: FILL <= 0.
     - Otherwise: FILL <= min(FILL+1, N).
  3. EN=0: HIST and FILL hold; Y <= 0.
- MATCH_CNT:
  - CLR_CNT=1 forces 0. This takes priority over a match in the same cycle; that match is not counted.
  - Otherwise it increments on each cycle where match=1 and saturates at 2^CW-1.
- OVERLAP is sampled every cycle. Changing it mid-stream affects only the next match decision.
- Matches require N valid bits accumulated since the last reset, LOAD, or (in non-overlap mode) the last match. Stale history before these events never contributes.
- Moore behaviour: Y is a pure register output with no combinational path from any input.

## Timing
- Latency: the final pattern bit is sampled on edge k and Y=1 during the cycle after edge k. Y is high for exactly one cycle per match.
- Back-to-back matches (e.g. pattern 11 with input 1,1,1 and OVERLAP=1) produce Y high on consecutive cycles.
- MATCH_CNT updates on the same edge that sets Y.
- The PATTERN output reflects LOAD one cycle after the LOAD edge. The first match with the new pattern is possible no earlier than N enabled bits after LOAD.
- Reset asserted mid-sequence clears everything immediately. The first match after reset release needs N fresh enabled bits.
- Gaps with EN=0 do not break a sequence; only enabled bits are counted.

## Test plan
- Overlap mode:
  - Setup: N=5, default pattern, OVERLAP=1, EN=1.
  - Stimulus: I=1,0,0,1,1,0,0,1,1.
  - Required: Y pulses after bits 5 and 9; MATCH_CNT=2.
- Non-overlap mode:
  - Same stream with OVERLAP=0.
  - Required: a single Y pulse after bit 5 (FILL cleared, so bits 6–9 are only 4 bits); MATCH_CNT=1.
- EN gating:
  - Stimulus: 1,0,0,1,1 with EN=0 cycles inserted between bits 2 and 3.
  - Required: Y pulse after the 5th enabled bit; Y=0 during all EN=0 cycles.
- Runtime LOAD:
  - Stimulus: LOAD with PATTERN_IN=5'b11100 after feeding 1,0,0,1. Then feed 1,1,1,0,0.
  - Required: no match on the earlier 10011 history; Y pulses after the final 0; PATTERN=11100.
- Asynchronous reset:
  - Stimulus: RST low between CLK edges after 1,0,0,1.
  - Required: Y, MATCH_CNT and FILL are 0 immediately. After release, a following bare 1 does not match; a full 1,0,0,1,1 matches.
- Counter saturation and clear:
  - Setup: CW=2, pattern 11, OVERLAP=1; feed 1s continuously.
  - Required: MATCH_CNT goes 1,2,3 and then stays at 3.
  - Stimulus: CLR_CNT asserted together with a match.
  - Required: MATCH_CNT=0 while Y=1.
